uart_rx_controller: RTL and testbench

//  UART receive engine, the receive-side counterpart to the UART TX path. It

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_sync2.sv | 24 ++
 rtl/uart_rx_controller.sv | 150 +++++++++++++++
 tb/tb_uart_rx_controller.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and default constants.
// Imported by the receive engine and its helpers.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK_WAIT
    } rx_state_t;

    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_DATA_BITS  = 8;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// Ports: clk, reset (sync, active-high), d (async in), q (synchronized out).
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_controller.sv
// UART receive engine: oversampled start/data/stop framing into the RX FIFO.
// Ports: clk, reset (sync, active-high), rx (async serial), baud_tick,
//        rxff (FIFO full) -> rx_fifo_push, rx_data, frame_err,
//        overrun_err (1-clk registered pulses), busy (not IDLE).
module uart_rx_controller
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = UART_DATA_BITS,
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    input  logic                 baud_tick,
    input  logic                 rxff,
    output logic                 rx_fifo_push,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 busy
);

    localparam int OS_W = $clog2(OVERSAMPLE);
    localparam int BC_W = $clog2(DATA_BITS + 1);

    localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0] OS_END  = OS_W'(OVERSAMPLE - 1);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_BITS - 1);

    logic rx_s;

    rx_state_t            state_q, state_d;
    logic [OS_W-1:0]      os_q, os_d;
    logic [BC_W-1:0]      bc_q, bc_d;
    logic [DATA_BITS-1:0] sh_q, sh_d;
    logic                 push_q, push_d;
    logic                 ferr_q, ferr_d;
    logic                 oerr_q, oerr_d;

    uart_sync2 #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (rx),
        .q    (rx_s)
    );

    always_comb begin
        state_d = state_q;
        os_d    = os_q;
        bc_d    = bc_q;
        sh_d    = sh_q;
        push_d  = 1'b0;
        ferr_d  = 1'b0;
        oerr_d  = 1'b0;
        if (baud_tick) begin
            unique case (state_q)
                IDLE: begin
                    // Hold the phase counter at zero so START counts
                    // from the tick that saw the falling edge.
                    os_d = '0;
                    if (!rx_s) begin
                        state_d = START;
                    end
                end
                START: begin
                    if (os_q == OS_MID) begin
                        os_d = '0;
                        if (rx_s) begin
                            state_d = IDLE;
                        end else begin
                            state_d = DATA;
                            bc_d    = '0;
                        end
                    end else begin
                        os_d = os_q + 1'b1;
                    end
                end
                DATA: begin
                    if (os_q == OS_END) begin
                        os_d = '0;
                        sh_d = {rx_s, sh_q[DATA_BITS-1:1]};
                        bc_d = bc_q + 1'b1;
                        if (bc_q == BC_LAST) begin
                            state_d = STOP;
                        end
                    end else begin
                        os_d = os_q + 1'b1;
                    end
                end
                STOP: begin
                    if (os_q == OS_END) begin
                        os_d = '0;
                        if (rx_s) begin
                            state_d = IDLE;
                            if (rxff) begin
                                oerr_d = 1'b1;
                            end else begin
                                push_d = 1'b1;
                            end
                        end else begin
                            // Low stop bit: flag once, then wait out
                            // any break before hunting for a start.
                            ferr_d  = 1'b1;
                            state_d = BRK_WAIT;
                        end
                    end else begin
                        os_d = os_q + 1'b1;
                    end
                end
                BRK_WAIT: begin
                    if (rx_s) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            os_q    <= '0;
            bc_q    <= '0;
            sh_q    <= '0;
            push_q  <= 1'b0;
            ferr_q  <= 1'b0;
            oerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            os_q    <= os_d;
            bc_q    <= bc_d;
            sh_q    <= sh_d;
            push_q  <= push_d;
            ferr_q  <= ferr_d;
            oerr_q  <= oerr_d;
        end
    end

    assign rx_fifo_push = push_q;
    assign frame_err    = ferr_q;
    assign overrun_err  = oerr_q;
    assign rx_data      = sh_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_controller.sv
// Self-checking bench for uart_rx_controller (16x oversample, 8 data bits).
// Frame-level model: each frame sent predicts one push/frame_err/overrun_err.
module tb_uart_rx_controller;

    localparam int BIT_CLK = 64;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic       baud_tick = 1'b0;
    logic       rxff = 1'b0;
    logic       rx_fifo_push;
    logic [7:0] rx_data;
    logic       frame_err;
    logic       overrun_err;
    logic       busy;

    typedef struct packed {
        logic [2:0] kind;
        logic [7:0] data;
    } exp_t;

    exp_t q[$];

    int         n_cmp = 0;
    int         n_bad = 0;
    int         push_cnt = 0;
    int         fe_cnt = 0;
    int         oe_cnt = 0;
    logic [7:0] last_data = 8'h00;
    int         tcnt = 0;

    uart_rx_controller dut (
        .clk         (clk),
        .reset       (reset),
        .rx          (rx),
        .baud_tick   (baud_tick),
        .rxff        (rxff),
        .rx_fifo_push(rx_fifo_push),
        .rx_data     (rx_data),
        .frame_err   (frame_err),
        .overrun_err (overrun_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(negedge clk);
            tcnt      = (tcnt + 1) % 4;
            baud_tick = (tcnt == 0);
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    exp_t       e_mon;
    logic [2:0] act_mon;

    always @(negedge clk) begin
        if (!reset && (rx_fifo_push || frame_err || overrun_err)) begin
            act_mon = {rx_fifo_push, frame_err, overrun_err};
            if (q.size() == 0) begin
                check("unexpected_pulse", 32'(act_mon), 32'd0);
            end else begin
                e_mon = q.pop_front();
                check("event_kind", 32'(act_mon), 32'(e_mon.kind));
                if (e_mon.kind == 3'b100) begin
                    check("push_data", 32'(rx_data), 32'(e_mon.data));
                end
            end
            if (rx_fifo_push) begin
                push_cnt++;
                last_data = rx_data;
            end
            if (frame_err) fe_cnt++;
            if (overrun_err) oe_cnt++;
        end
    end

    task automatic bit_out(input logic v);
        rx = v;
        repeat (BIT_CLK) @(negedge clk);
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        repeat (n * BIT_CLK) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stopb,
                              input logic ff);
        exp_t e;
        e.data = d;
        if (!stopb) e.kind = 3'b010;
        else if (ff) e.kind = 3'b001;
        else e.kind = 3'b100;
        q.push_back(e);
        rxff = ff;
        bit_out(1'b0);
        for (int i = 0; i < 8; i++) bit_out(d[i]);
        bit_out(stopb);
    endtask

    int         p0, f0, o0;
    int         r;
    int         gap;
    logic [7:0] rd;
    logic       rs;
    logic       rf;

    initial begin
        repeat (5) @(negedge clk);
        check("reset_outputs",
              32'({busy, rx_fifo_push, frame_err, overrun_err, rx_data}), 32'd0);
        reset = 1'b0;
        idle_bits(2);

        // 1: clean 0xA5
        p0 = push_cnt; f0 = fe_cnt; o0 = oe_cnt;
        fork
            send_frame(8'hA5, 1'b1, 1'b0);
            begin
                repeat (200) @(negedge clk);
                check("busy_mid_frame", 32'(busy), 32'd1);
            end
        join
        check("t1_busy_after_stop", 32'(busy), 32'd0);
        idle_bits(1);
        check("t1_push_count", 32'(push_cnt - p0), 32'd1);
        check("t1_data", 32'(last_data), 32'hA5);
        check("t1_no_errors", 32'((fe_cnt - f0) + (oe_cnt - o0)), 32'd0);

        // 2: short low glitch
        p0 = push_cnt; f0 = fe_cnt; o0 = oe_cnt;
        rx = 1'b0;
        repeat (12) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        check("t2_idle_after_glitch", 32'(busy), 32'd0);
        idle_bits(1);
        check("t2_no_events",
              32'((push_cnt - p0) + (fe_cnt - f0) + (oe_cnt - o0)), 32'd0);

        // 3: framing error then break, then recovery
        p0 = push_cnt; f0 = fe_cnt;
        send_frame(8'h3C, 1'b0, 1'b0);
        rx = 1'b0;
        repeat (20 * BIT_CLK) @(negedge clk);
        idle_bits(2);
        check("t3_one_frame_err", 32'(fe_cnt - f0), 32'd1);
        check("t3_no_push", 32'(push_cnt - p0), 32'd0);
        send_frame(8'h55, 1'b1, 1'b0);
        idle_bits(1);
        check("t3_recover_data", 32'(last_data), 32'h55);

        // 4: overrun, then clean repeat
        p0 = push_cnt; o0 = oe_cnt;
        send_frame(8'h7E, 1'b1, 1'b1);
        idle_bits(1);
        check("t4_overrun", 32'(oe_cnt - o0), 32'd1);
        check("t4_no_push", 32'(push_cnt - p0), 32'd0);
        send_frame(8'h7E, 1'b1, 1'b0);
        idle_bits(1);
        check("t4_push_data", 32'(last_data), 32'h7E);

        // 5: reset during data bit 4 of 0xF0
        p0 = push_cnt;
        rxff = 1'b0;
        bit_out(1'b0);
        for (int i = 0; i < 4; i++) bit_out(1'b0);
        rx = 1'b1;
        repeat (BIT_CLK / 2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("t5_reset_outputs",
              32'({busy, rx_fifo_push, frame_err, overrun_err, rx_data}), 32'd0);
        reset = 1'b0;
        idle_bits(2);
        check("t5_no_partial_push", 32'(push_cnt - p0), 32'd0);
        send_frame(8'h3C, 1'b1, 1'b0);
        idle_bits(1);
        check("t5_next_data", 32'(last_data), 32'h3C);

        // 6: back-to-back
        p0 = push_cnt;
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        idle_bits(1);
        check("t6_two_pushes", 32'(push_cnt - p0), 32'd2);
        check("t6_last_data", 32'(last_data), 32'hFF);

        // randomized frames, errors, overruns and glitches
        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                rx = 1'b0;
                repeat (4 * $urandom_range(1, 5)) @(negedge clk);
                idle_bits(1);
            end else begin
                rd = 8'($urandom);
                rs = ($urandom_range(0, 4) != 0);
                rf = ($urandom_range(0, 3) == 0);
                send_frame(rd, rs, rf);
                gap = rs ? $urandom_range(0, 2) : $urandom_range(1, 2);
                idle_bits(gap);
            end
        end

        idle_bits(2);
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
